imem_loader: RTL
================

// Module: imem_loader
// PURPOSE
//   Instruction-side partner of the 8-bit core: owns the 256x9 instruction memory.
//   Fills it from a byte stream (valid/ready) at boot, holding the core in reset meanwhile.
//   Then serves inst = mem[pc] combinationally to the core's fetch port.
//   Sits between the boot/host byte source and the core's pc/inst pins.
// PARAMETERS
//   ADDR_W   8     instruction address width (matches core pc)
//   INST_W   9     instruction width (opcode inst[8:3])
//   DEPTH    256   memory entries, = 2**ADDR_W
// PORTS
//   clk        in   1       system clock, rising edge
//   rst        in   1       reset, asynchronous, active-low
//   in_valid   in   1       load byte valid
//   in_data    in   8       load byte
//   in_ready   out  1       loader accepts byte this cycle
//   reload     in   1       restart: clear + load again (sampled in S_RUN/S_ERR only)
//   pc         in   ADDR_W  core fetch address
//   inst       out  INST_W  instruction to core; 9'h000 unless in S_RUN
//   cpu_rst    out  1       active-high reset to core; 0 only in S_RUN
//   load_done  out  1       1 in S_RUN
//   load_err   out  1       1 in S_ERR
// BEHAVIOUR
//   Reset (rst=0): state=S_CLR, clr_addr=0, in_ready=0, cpu_rst=1, load_done=0, load_err=0,
//     chk=0, inst=0. RAM contents are not reset; S_CLR clears them.
//   Byte transfer = in_valid & in_ready on a rising edge; in_valid may gap freely.
//   Stream format: LEN, {LO,HI} x count, CHK. count = LEN, LEN=0 means 256.
//   States:
//   S_CLR : write 9'h000 to mem[clr_addr], clr_addr++; after addr 255 (256 cycles) -> S_LEN.
//   S_LEN : in_ready=1; on xfer: remain=count (9b), waddr=0, chk=in_data -> S_LO.
//   S_LO  : in_ready=1; on xfer: lo=in_data, chk^=in_data -> S_HI.
//   S_HI  : in_ready=1; on xfer: if in_data[7:1]!=0 -> S_ERR (no write). Else
//           mem[waddr]={in_data[0],lo}, waddr++ (8b wrap), remain--, chk^=in_data;
//           remain reaching 0 -> S_CHK, else -> S_LO.
//   S_CHK : in_ready=1; on xfer: in_data==chk -> S_RUN, else -> S_ERR.
//   S_RUN : in_ready=0, cpu_rst=0, load_done=1, inst=mem[pc] (async read, 0-cycle).
//   S_ERR : in_ready=0, cpu_rst=1, load_err=1; held until reset or reload.
//   reload=1 in S_RUN/S_ERR -> S_CLR next cycle (cpu_rst=1 that edge onward); ignored elsewhere.
//   All outputs registered or decoded from registered state only; no in_valid->in_ready path.
//   pc beyond loaded range reads cleared entries (9'h000). pc 8-bit, no bounds check.
//   Async reset mid-load: immediate return to reset values; partial image discarded by S_CLR.
//   Write port: one synchronous write/cycle (S_CLR or S_HI xfer), never both.
// STRUCTURE
//   Shared header isa_defs.vh: INST_W, ADDR_W, NOP encoding 9'h000, loader state encodings.
//   One sub-module: imem_ram (DEPTH x INST_W, 1 sync write port, 1 async read port).
//   imem_loader = FSM + counters (clr_addr, waddr, remain) + chk register + output decode.
// TESTING
//   1 Release rst -> in_ready=0, cpu_rst=1 for exactly 256 cycles, then in_ready=1 (S_LEN).
//   2 Send 02,34,01,7F,00,48 -> load_done=1, cpu_rst=0; pc=0 inst=9'h134, pc=1 9'h07F,
//     pc=2 9'h000; insert random in_valid gaps, same result.
//   3 Same stream with CHK=00 -> load_err=1, cpu_rst=1, in_ready=0, inst=0; reload -> S_CLR.
//   4 Send 01,55,02 -> load_err=1 on the HI byte, mem[0] remains 9'h000 after reload.
//   5 LEN=00, 256 pairs with LO=addr, HI=addr[0]; correct CHK -> inst at pc=255 is 9'h1FF,
//     pc=0 is 9'h000.
//   6 rst low after 3 bytes of test 2 -> outputs reset same cycle; rerun test 2 passes;
//     reload pulse in S_RUN while in_valid=1 -> reload wins, no byte consumed.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared widths, the NOP encoding and the loader state encodings for the
// instruction-memory loader.
package imem_loader_pkg;

  localparam int ADDR_W = 8;
  localparam int INST_W = 9;
  localparam int DEPTH  = 1 << ADDR_W;

  localparam logic [INST_W-1:0] INST_NOP = 9'h000;

  typedef enum logic [2:0] {
    S_CLR = 3'd0,
    S_LEN = 3'd1,
    S_LO  = 3'd2,
    S_HI  = 3'd3,
    S_CHK = 3'd4,
    S_RUN = 3'd5,
    S_ERR = 3'd6
  } state_t;

endpackage

// File: rtl/imem_ram.sv
// Instruction memory: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; the loader clears them itself.
module imem_ram
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [INST_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [INST_W-1:0] rdata_o
);

  logic [INST_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/imem_loader.sv
// Boot loader for the core's instruction memory: clears it, fills it from a
// LEN/{LO,HI}xN/CHK byte stream, then serves inst = mem[pc] with the core released.
//   state | meaning
//   S_CLR | writing NOP to every entry
//   S_LEN | waiting for length byte (0 means 256)
//   S_LO  | waiting for low instruction byte
//   S_HI  | waiting for high byte (only bit 0 may be set)
//   S_CHK | waiting for xor checksum byte
//   S_RUN | image good, core running
//   S_ERR | bad image, core held until reset or reload
module imem_loader
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              reload,
  input  logic [ADDR_W-1:0] pc,
  output logic [INST_W-1:0] inst,
  output logic              cpu_rst,
  output logic              load_done,
  output logic              load_err
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [8:0]        remain_q, remain_d;
  logic [7:0]        chk_q, chk_d;
  logic [7:0]        lo_q, lo_d;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [INST_W-1:0] ram_wdata;
  logic [INST_W-1:0] ram_rdata;
  logic              xfer;

  // Ready depends on state only, so there is no in_valid -> in_ready path.
  assign in_ready  = (state_q == S_LEN) || (state_q == S_LO) ||
                     (state_q == S_HI)  || (state_q == S_CHK);
  assign cpu_rst   = (state_q != S_RUN);
  assign load_done = (state_q == S_RUN);
  assign load_err  = (state_q == S_ERR);
  assign inst      = (state_q == S_RUN) ? ram_rdata : INST_NOP;
  assign xfer      = in_valid & in_ready;

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    waddr_d    = waddr_q;
    remain_d   = remain_q;
    chk_d      = chk_q;
    lo_d       = lo_q;
    ram_we     = 1'b0;
    ram_waddr  = clr_addr_q;
    ram_wdata  = INST_NOP;
    case (state_q)
      S_CLR: begin
        ram_we     = 1'b1;
        clr_addr_d = clr_addr_q + 8'd1;
        if (clr_addr_q == 8'hFF) state_d = S_LEN;
      end
      S_LEN: begin
        if (xfer) begin
          remain_d = (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
          waddr_d  = '0;
          chk_d    = in_data;
          state_d  = S_LO;
        end
      end
      S_LO: begin
        if (xfer) begin
          lo_d    = in_data;
          chk_d   = chk_q ^ in_data;
          state_d = S_HI;
        end
      end
      S_HI: begin
        if (xfer) begin
          if (in_data[7:1] != 7'd0) begin
            state_d = S_ERR;
          end else begin
            ram_we    = 1'b1;
            ram_waddr = waddr_q;
            ram_wdata = {in_data[0], lo_q};
            waddr_d   = waddr_q + 8'd1;
            remain_d  = remain_q - 9'd1;
            chk_d     = chk_q ^ in_data;
            state_d   = (remain_q == 9'd1) ? S_CHK : S_LO;
          end
        end
      end
      S_CHK: begin
        if (xfer) state_d = (in_data == chk_q) ? S_RUN : S_ERR;
      end
      S_RUN, S_ERR: begin
        if (reload) begin
          state_d    = S_CLR;
          clr_addr_d = '0;
        end
      end
      default: state_d = S_CLR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_CLR;
      clr_addr_q <= '0;
      waddr_q    <= '0;
      remain_q   <= '0;
      chk_q      <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      waddr_q    <= waddr_d;
      remain_q   <= remain_d;
      chk_q      <= chk_d;
      lo_q       <= lo_d;
    end
  end

  imem_ram u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (pc),
    .rdata_o (ram_rdata)
  );

endmodule
